// File: rtl/fetch_queue_unit.sv
// Prefetching fetch unit: requests aligned lines from the I-cache, buffers words in a
// circular queue and presents one variable-length instruction per cycle to decode.
module fetch_queue_unit #(
  parameter int FETCH_WORDS = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter int PC_W        = 16,
  parameter int IMM_BIT     = 15
) (
  input  logic                     clk,
  input  logic                     a_rst,
  output logic                     fetch_req,
  output logic [PC_W-1:0]          fetch_addr,
  input  logic                     fetch_ack,
  input  logic [16*FETCH_WORDS-1:0] fetch_opc,
  input  logic                     hold,
  input  logic                     pc_w,
  input  logic [PC_W-1:0]          pc_alu,
  input  logic                     pc_inv,
  output logic [PC_W-1:0]          pc_out,
  output logic [15:0]              ir_out,
  output logic [15:0]              k16_out,
  output logic                     ir_len,
  output logic                     ir_valid
);

  localparam int QA = $clog2(QUEUE_DEPTH);
  localparam int CW = QA + 1;
  localparam int SW = $clog2(FETCH_WORDS);
  localparam int LB = SW + 1;

  function automatic logic [PC_W-1:0] line_base(input logic [PC_W-1:0] a);
    return {a[PC_W-1:LB], {LB{1'b0}}};
  endfunction

  function automatic logic [SW-1:0] word_skip(input logic [PC_W-1:0] a);
    return a[LB-1:1];
  endfunction

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fptr_q;
  logic [SW-1:0]   skip_q;
  logic [QA-1:0]   head_q;
  logic [CW-1:0]   count_q;
  logic            run_q;
  logic [15:0]     mem [QUEUE_DEPTH];

  logic [15:0]     head_word;
  logic [15:0]     next_word;
  logic            is_long;
  logic            valid;
  logic            req;
  logic            accept;
  logic            consume;
  logic [CW-1:0]   space;
  logic [CW-1:0]   pop_n;
  logic [CW-1:0]   wr_n;
  logic [QA-1:0]   tail;
  logic            wr_en   [FETCH_WORDS];
  logic [QA-1:0]   wr_idx  [FETCH_WORDS];
  logic [15:0]     wr_word [FETCH_WORDS];

  assign head_word = mem[head_q];
  assign next_word = mem[head_q + QA'(1)];
  assign is_long   = head_word[IMM_BIT];

  // The immediate of a long instruction must already be queued before it is presented.
  assign valid = (count_q != '0) & (~is_long | (count_q >= CW'(2))) & ~pc_inv;

  assign space   = CW'(QUEUE_DEPTH) - count_q;
  assign req     = run_q & ~pc_inv & (space >= CW'(FETCH_WORDS));
  assign accept  = req & fetch_ack & ~pc_w;
  assign consume = valid & ~hold & ~pc_w;
  assign pop_n   = consume ? (is_long ? CW'(2) : CW'(1)) : '0;
  assign wr_n    = accept ? (CW'(FETCH_WORDS) - CW'(skip_q)) : '0;
  assign tail    = head_q + count_q[QA-1:0];

  // Line words before the skip point precede the target pc and are dropped.
  always_comb begin
    for (int i = 0; i < FETCH_WORDS; i++) begin
      wr_en[i]   = accept & (CW'(i) >= CW'(skip_q));
      wr_idx[i]  = tail + QA'(i) - QA'(skip_q);
      wr_word[i] = fetch_opc[16*(FETCH_WORDS-i)-1 -: 16];
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      pc_q    <= '0;
      fptr_q  <= '0;
      skip_q  <= '0;
      head_q  <= '0;
      count_q <= '0;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (pc_w) begin
        pc_q    <= pc_alu;
        fptr_q  <= line_base(pc_alu);
        skip_q  <= word_skip(pc_alu);
        head_q  <= '0;
        count_q <= '0;
      end else if (pc_inv) begin
        fptr_q  <= line_base(pc_q);
        skip_q  <= word_skip(pc_q);
        head_q  <= '0;
        count_q <= '0;
      end else begin
        if (consume) begin
          head_q <= head_q + pop_n[QA-1:0];
          pc_q   <= pc_q + (is_long ? PC_W'(4) : PC_W'(2));
        end
        if (accept) begin
          skip_q <= '0;
          fptr_q <= fptr_q + PC_W'(2*FETCH_WORDS);
        end
        count_q <= count_q + wr_n - pop_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WORDS; i++) begin
      if (wr_en[i]) mem[wr_idx[i]] <= wr_word[i];
    end
  end

  assign fetch_req  = req;
  assign fetch_addr = fptr_q;
  assign pc_out     = pc_q;
  assign ir_valid   = valid;
  assign ir_len     = valid & is_long;
  assign ir_out     = valid ? head_word : 16'h0000;
  assign k16_out    = (valid & is_long) ? next_word : 16'h0000;

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parametrised prefetching fetch unit for the 16-bit-word core: it requests aligned multi-word lines from the instruction cache, buffers them in a word queue and presents one decoded-length instruction per cycle (opcode plus optional 16-bit immediate) to the decode stage. It sits between the I-cache port and decode, and adds configurable fetch width, queue depth, variable-length instructions, unaligned redirects and cache back-pressure on top of the single-line fetch unit.

## Interface
- FETCH_WORDS, 2, 16-bit words per fetch line; power of two, 2 or 4
- QUEUE_DEPTH, 8, queue capacity in words; power of two, ≥ 2*FETCH_WORDS
- PC_W, 16, byte-address width
- IMM_BIT, 15, opcode bit that marks a two-word instruction (immediate follows)

- clk  in  1  single clock, rising edge
- a_rst  in  1  asynchronous, active-high reset
- fetch_req  out  1  line request valid
- fetch_addr  out  PC_W  byte address of requested line, aligned to 2*FETCH_WORDS
- fetch_ack  in  1  fetch_opc holds the line at fetch_addr this cycle
- fetch_opc  in  16*FETCH_WORDS  line data, lowest-addressed word in MSBs
- hold  in  1  decode stall; no instruction consumed
- pc_w  in  1  redirect to pc_alu
- pc_alu  in  PC_W  redirect target, byte address, even
- pc_inv  in  1  flush queue and suppress output while high
- pc_out  out  PC_W  byte address of presented instruction
- ir_out  out  16  opcode word
- k16_out  out  16  immediate word (0 for one-word instructions)
- ir_len  out  1  1 = two-word instruction
- ir_valid  out  1  ir_out/k16_out/pc_out valid

## Operation
- State: pc_out register, line-aligned fetch pointer, skip count, circular word queue (head, count), run flag.
- Reset: pc_out = 0, fetch pointer = 0, skip = 0, count = 0, run = 0; outputs fetch_req = 0, fetch_addr = 0, ir_valid = 0, ir_len = 0, ir_out = k16_out = 0.
- run sets on the first rising edge after a_rst deasserts.
- fetch_req = run & ~pc_inv & (QUEUE_DEPTH − count ≥ FETCH_WORDS); fetch_addr = fetch pointer. Single outstanding request; fetch_addr changes only on accepted ack, redirect or reset.
- Accepted ack (fetch_req & fetch_ack, no pc_w/pc_inv this cycle): write words skip..FETCH_WORDS−1 in address order, clear skip, fetch pointer += 2*FETCH_WORDS mod 2^PC_W.
- Output: head word H. Long = H[IMM_BIT]. ir_valid = (count ≥ 1) & (~Long | count ≥ 2) & ~pc_inv. ir_out = H, k16_out = next word when long, ir_len = Long; all data outputs 0 when ir_valid = 0.
- Consume on ir_valid & ~hold: pop 1 or 2 words, pc_out += 2 or 4 mod 2^PC_W.
- Redirect (pc_w): flush queue, pc_out = pc_alu, fetch pointer = pc_alu aligned down, skip = (pc_alu >> 1) mod FETCH_WORDS. Applies regardless of hold. Ack in the same cycle is discarded.
- pc_inv without pc_w: flush queue, fetch pointer = pc_out aligned down, skip recomputed from pc_out; pc_out holds. Ack discarded. pc_w and pc_inv together: pc_w wins.
- Ack and consume in the same cycle: both apply; count += written − popped.
- Long instruction straddling a line: ir_valid stays 0 until the immediate word is queued.

## Timing
- Redirect at edge N: fetch_addr updated after N; with zero-wait ack, data enters the queue at N+1 and ir_valid = 1 in cycle N+1..N+2 (combinational from queue).
- Sustained throughput: 1 instruction per cycle when fetch bandwidth ≥ consumption.
- a_rst takes effect immediately (asynchronously) at any point, discarding in-flight data.

## Test plan
- Reset: a_rst high → all outputs 0. Release with word w = w at ack every cycle → fetch_req = 1, fetch_addr = 0 after the first edge. ir_out sequence 0x0000, 0x0001, 0x0002 with pc_out 0, 2, 4.
- Unaligned redirect: pc_w with pc_alu = 0x0006 (FETCH_WORDS = 2) → fetch_addr = 0x0004, first ir_out = 0x0003, pc_out = 6, word 2 never presented. Repeat at FETCH_WORDS = 4 with pc_alu = 0x000A → skip = 1, first ir_out = word 5.
- Long instruction: word 3 = 0x8123, word 4 = 0xBEEF, delay the second line 3 cycles → ir_valid = 0 until it arrives, then ir_out = 0x8123, k16_out = 0xBEEF, ir_len = 1, next pc_out = pc + 4.
- Back-pressure: hold = 1 for 10 cycles → count reaches 8, fetch_req = 0. Release hold → stream resumes at the next word with no loss or duplication; wrap of queue indices exercised.
- pc_inv high 3 cycles mid-stream → ir_valid = 0, fetch_req = 0, pc_out held. On drop, refetch from aligned pc_out and the same instruction is re-presented.
- fetch_ack coincident with pc_w → data dropped, first ir_out comes from the pc_alu line. a_rst pulsed mid-stream → outputs 0 immediately and restart at 0.
